// File: rtl/fmap_buf_pkg.sv
// Shared types and constants for the two-bank feature-map buffer.
package fmap_buf_pkg;

   localparam int NUM_BANKS = 2;

   typedef logic [0:0] bank_idx_t;
   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/bhv_sram.sv
// Behavioural two-port SRAM: port A synchronous read, port B write, both enables active-low.
module bhv_sram #(
   parameter int WWORD = 96,
   parameter int WADDR = 10,
   parameter int DEPTH = 1024
) (
   input  logic             clk,
   input  logic             cena,
   input  logic [WADDR-1:0] aa,
   output logic [WWORD-1:0] qa,
   input  logic             cenb,
   input  logic [WADDR-1:0] ab,
   input  logic [WWORD-1:0] db
);

   logic [WWORD-1:0] mem_r [DEPTH];

   // Port A read: data appears the cycle after cena is asserted.
   always_ff @(posedge clk) begin
      if (!cena) begin
         qa <= mem_r[aa];
      end
   end

   // Port B write.
   always_ff @(posedge clk) begin
      if (!cenb) begin
         mem_r[ab] <= db;
      end
   end

endmodule

// File: rtl/pingpong_fmap_buf_ctrl.sv
// Bank pointers, write address, occupancy counter and read-valid tracking
// for the ping-pong buffer.
module pingpong_fmap_buf_ctrl
   import fmap_buf_pkg::*;
#(
   parameter int W_ADDR    = 10,
   parameter int FRAME_LEN = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              rd_done,
   output logic              wr_ready,
   output logic              rd_bank_ready,
   output logic [W_ADDR-1:0] wr_aa,
   output bank_idx_t         wr_bank,
   output bank_idx_t         rd_bank,
   output bank_idx_t         rd_sel,
   output logic              rd_valid,
   output logic              overflow,
   output logic              wr_accept,
   output logic              rd_accept
);

   localparam logic [W_ADDR-1:0] LAST_AA = W_ADDR'(FRAME_LEN - 1);

   logic [W_ADDR-1:0] wr_aa_r;
   bank_idx_t         wr_bank_r;
   bank_idx_t         rd_bank_r;
   bank_idx_t         rd_sel_r;
   occ_t              full_cnt_r;
   logic              overflow_r;
   logic              rd_valid_r;

   logic              wr_ready_s;
   logic              rd_ready_s;
   logic              wr_accept_s;
   logic              rd_accept_s;
   logic              release_s;
   logic              frame_done_s;
   occ_t              full_cnt_nxt_s;

   // Handshake decode and occupancy next-state; nothing is accepted in a clearing cycle.
   always_comb begin
      wr_ready_s   = (full_cnt_r != OCC_FULL);
      rd_ready_s   = (full_cnt_r != OCC_EMPTY);
      wr_accept_s  = wr_en   && wr_ready_s && !go && !rst;
      rd_accept_s  = rd_en   && rd_ready_s && !go && !rst;
      release_s    = rd_done && rd_ready_s && !go && !rst;
      frame_done_s = wr_accept_s && (wr_aa_r == LAST_AA);
      case ({frame_done_s, release_s})
         2'b10:   full_cnt_nxt_s = full_cnt_r + OCC_ONE;
         2'b01:   full_cnt_nxt_s = full_cnt_r - OCC_ONE;
         default: full_cnt_nxt_s = full_cnt_r;
      endcase
   end

   // Pointer, occupancy and status registers.
   always_ff @(posedge clk) begin
      if (rst || go) begin
         wr_aa_r    <= {W_ADDR{1'b0}};
         wr_bank_r  <= 1'b0;
         rd_bank_r  <= 1'b0;
         rd_sel_r   <= 1'b0;
         full_cnt_r <= OCC_EMPTY;
         overflow_r <= 1'b0;
         rd_valid_r <= 1'b0;
      end else begin
         if (wr_accept_s) begin
            if (frame_done_s) begin
               wr_aa_r   <= {W_ADDR{1'b0}};
               wr_bank_r <= ~wr_bank_r;
            end else begin
               wr_aa_r   <= wr_aa_r + {{(W_ADDR-1){1'b0}}, 1'b1};
            end
         end
         if (wr_en && !wr_ready_s) begin
            overflow_r <= 1'b1;
         end
         if (release_s) begin
            rd_bank_r <= ~rd_bank_r;
         end
         // rd_sel captures the pre-toggle bank so a read issued with rd_done returns from it.
         if (rd_accept_s) begin
            rd_sel_r <= rd_bank_r;
         end
         full_cnt_r <= full_cnt_nxt_s;
         rd_valid_r <= rd_accept_s;
      end
   end

   assign wr_ready      = wr_ready_s;
   assign rd_bank_ready = rd_ready_s;
   assign wr_aa         = wr_aa_r;
   assign wr_bank       = wr_bank_r;
   assign rd_bank       = rd_bank_r;
   assign rd_sel        = rd_sel_r;
   assign rd_valid      = rd_valid_r;
   assign overflow      = overflow_r;
   assign wr_accept     = wr_accept_s;
   assign rd_accept     = rd_accept_s;

endmodule

// File: rtl/pingpong_fmap_buf.sv
// Two-bank ping-pong feature-map buffer: the producer fills one bank while the
// consumer randomly reads the other.
module pingpong_fmap_buf
   import fmap_buf_pkg::*;
#(
   parameter int DEPTH     = 1024,
   parameter int WIDTH     = 96,
   parameter int W_ADDR    = 10,
   parameter int FRAME_LEN = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              wr_ready,
   output logic [W_ADDR-1:0] wr_aa,
   input  logic              rd_en,
   input  logic [W_ADDR-1:0] rd_aa,
   input  logic              rd_done,
   output logic              rd_bank_ready,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic              rd_bank,
   output logic              overflow
);

   bank_idx_t         wr_bank_s;
   bank_idx_t         rd_bank_s;
   bank_idx_t         rd_sel_s;
   logic              wr_accept_s;
   logic              rd_accept_s;
   logic              rd_valid_s;
   logic [W_ADDR-1:0] wr_aa_s;
   logic [WIDTH-1:0]  q_s [NUM_BANKS];

   pingpong_fmap_buf_ctrl #(
      .W_ADDR    (W_ADDR),
      .FRAME_LEN (FRAME_LEN)
   ) u_ctrl (
      .clk           (clk),
      .rst           (rst),
      .go            (go),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .rd_done       (rd_done),
      .wr_ready      (wr_ready),
      .rd_bank_ready (rd_bank_ready),
      .wr_aa         (wr_aa_s),
      .wr_bank       (wr_bank_s),
      .rd_bank       (rd_bank_s),
      .rd_sel        (rd_sel_s),
      .rd_valid      (rd_valid_s),
      .overflow      (overflow),
      .wr_accept     (wr_accept_s),
      .rd_accept     (rd_accept_s)
   );

   // Only the bank owning the access is enabled; the other keeps both enables high.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic cena_s;
      logic cenb_s;

      assign cena_s = !(rd_accept_s && (rd_bank_s == bank_idx_t'(b)));
      assign cenb_s = !(wr_accept_s && (wr_bank_s == bank_idx_t'(b)));

      bhv_sram #(
         .WWORD (WIDTH),
         .WADDR (W_ADDR),
         .DEPTH (DEPTH)
      ) u_sram (
         .clk  (clk),
         .cena (cena_s),
         .aa   (rd_aa),
         .qa   (q_s[b]),
         .cenb (cenb_s),
         .ab   (wr_aa_s),
         .db   (wr_data)
      );
   end

   // Read data is forced to zero whenever it is not valid.
   always_comb begin
      if (rd_valid_s) begin
         rd_data = q_s[rd_sel_s];
      end else begin
         rd_data = {WIDTH{1'b0}};
      end
   end

   assign wr_aa    = wr_aa_s;
   assign rd_valid = rd_valid_s;
   assign rd_bank  = rd_bank_s;

endmodule
